// File: rtl/fifo_adapter_pkg.sv
// ============================================================================
// fifo_adapter_pkg : shared constants for the FIFO read-side stream adapter
// Rev 1.0
// ============================================================================
`default_nettype none

package fifo_adapter_pkg;

  localparam int MAX_RD_LATENCY = 2;

  // One entry per beat that can be in flight, plus one to cover the pop/refill turnaround.
  function automatic int buf_depth(input int lat);
    return lat + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_rd_prefetch_buf.sv
// ============================================================================
// fifo_rd_prefetch_buf : small register-array FIFO holding prefetched beats
// Rev 1.0
// ============================================================================
`default_nettype none

module fifo_rd_prefetch_buf #(
  parameter int DSIZE = 18,
  parameter int DEPTH = 2
) (
  input  logic                         rd_clk,
  input  logic                         rd_rst,
  input  logic                         wr,
  input  logic [DSIZE-1:0]             wdata,
  input  logic                         rd,
  output logic [DSIZE-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [DSIZE-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    occ_q, occ_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (wr) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    // Simultaneous write and read leaves the count untouched.
    case ({wr, rd})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign rdata     = mem_q[rd_ptr_q];
  assign occupancy = occ_q;
  assign full      = (occ_q == CW'(DEPTH));
  assign empty     = (occ_q == '0);

`ifndef SYNTHESIS
  a_no_read_when_empty: assert property (@(posedge rd_clk) disable iff (rd_rst) !(rd && empty));
`endif

endmodule

`default_nettype wire

// File: rtl/fifo_rd_stream_adapter.sv
// ============================================================================
// fifo_rd_stream_adapter : latency-based FIFO read port -> valid/ready stream
// Optional beat counter: define FIFO_RD_ADAPTER_BEATCNT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module fifo_rd_stream_adapter
  import fifo_adapter_pkg::*;
#(
  parameter int DSIZE      = 18,
  parameter int RD_LATENCY = 1
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             fifo_empty,
  input  logic [DSIZE-1:0] fifo_dout,
  output logic             fifo_rd_en,
  output logic [DSIZE-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [31:0]      beat_cnt
);

  localparam int BUF_DEPTH = buf_depth(RD_LATENCY);
  localparam int OW        = $clog2(BUF_DEPTH + 1);
  localparam int UW        = OW + 1;

  if ((RD_LATENCY < 1) || (RD_LATENCY > MAX_RD_LATENCY)) begin : g_bad_latency
    $error("fifo_rd_stream_adapter: RD_LATENCY must be 1 or 2");
  end

  logic [RD_LATENCY-1:0] pipe_q, pipe_d;
  logic [OW-1:0]         inflight_q, inflight_d;
  logic [OW-1:0]         occupancy;
  logic [UW-1:0]         used_after_pop;
  logic                  buf_full, buf_empty;
  logic                  pop, wr;

  assign pop = m_tvalid && m_tready;
  // The oldest strobe in the pipe marks the cycle its data sits on fifo_dout.
  assign wr  = pipe_q[RD_LATENCY-1];

  always_comb begin
    used_after_pop = UW'(inflight_q) + UW'(occupancy) - UW'(pop);
    fifo_rd_en     = !fifo_empty && (used_after_pop < UW'(BUF_DEPTH));
    pipe_d         = RD_LATENCY'({pipe_q, fifo_rd_en});
    inflight_d     = inflight_q + OW'(fifo_rd_en) - OW'(wr);
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      pipe_q     <= '0;
      inflight_q <= '0;
    end else begin
      pipe_q     <= pipe_d;
      inflight_q <= inflight_d;
    end
  end

  fifo_rd_prefetch_buf #(
    .DSIZE (DSIZE),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .rd_clk    (rd_clk),
    .rd_rst    (rd_rst),
    .wr        (wr),
    .wdata     (fifo_dout),
    .rd        (pop),
    .rdata     (m_tdata),
    .occupancy (occupancy),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  assign m_tvalid = !buf_empty;

`ifdef FIFO_RD_ADAPTER_BEATCNT_EN
  logic [31:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    beat_cnt_d = pop ? beat_cnt_q + 32'd1 : beat_cnt_q;
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign beat_cnt = beat_cnt_q;
`else
  assign beat_cnt = '0;
`endif

`ifndef SYNTHESIS
  a_no_write_when_full: assert property (@(posedge rd_clk) disable iff (rd_rst) !(wr && buf_full));
  a_axis_hold: assert property (@(posedge rd_clk) disable iff (rd_rst)
    (m_tvalid && !m_tready) |=> (m_tvalid && $stable(m_tdata)));
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_stream_adapter.sv
// ============================================================================
// tb_fifo_rd_stream_adapter : scoreboard bench, RD_LATENCY=1 and 2 lanes side by side
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fifo_rd_stream_adapter;

  localparam int DSIZE = 18;
`ifdef FIFO_RD_ADAPTER_BEATCNT_EN
  localparam bit BEATCNT_EN = 1'b1;
`else
  localparam bit BEATCNT_EN = 1'b0;
`endif

  logic             clk      = 1'b0;
  logic             rst      = 1'b1;
  logic             wr_req   = 1'b0;
  logic [DSIZE-1:0] wr_data  = '0;
  logic             m_tready = 1'b0;
  int               vectors     = 0;
  int               miscompares = 0;

  always #5 clk = ~clk;

  task automatic check(input int lane, input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL lane%0d %s: got 0x%0h, expected 0x%0h", lane, name, act, exp);
    end
  endtask

  // Lane gi runs an adapter with RD_LATENCY = gi+1 against its own FIFO model.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    localparam int LAT = gi + 1;

    logic             empty, rd_en, tvalid;
    logic [DSIZE-1:0] dout, tdata;
    logic [31:0]      bcnt;
    logic [DSIZE-1:0] fmem [0:16383];
    logic [13:0]      fw, fr;
    logic [DSIZE-1:0] stg [LAT];
    logic [DSIZE-1:0] exp_q [$];
    int               rd_cnt, pop_cnt;
    logic [31:0]      bc_exp;
    logic [31:0]      bc_off     = '0;
    logic             stall_prev = 1'b0;
    logic [DSIZE-1:0] data_prev  = '0;

    assign empty = (fw == fr);
    assign dout  = stg[LAT-1];

    fifo_rd_stream_adapter #(
      .DSIZE      (DSIZE),
      .RD_LATENCY (LAT)
    ) u_dut (
      .rd_clk     (clk),
      .rd_rst     (rst),
      .fifo_empty (empty),
      .fifo_dout  (dout),
      .fifo_rd_en (rd_en),
      .m_tdata    (tdata),
      .m_tvalid   (tvalid),
      .m_tready   (m_tready),
      .beat_cnt   (bcnt)
    );

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        fw      <= '0;
        fr      <= '0;
        rd_cnt  <= 0;
        pop_cnt <= 0;
        bc_exp  <= '0;
        for (int k = 0; k < LAT; k++) stg[k] <= '0;
      end else begin
        if (wr_req) begin
          fmem[fw] <= wr_data;
          fw       <= fw + 14'd1;
        end
        if (rd_en) begin
          fr     <= fr + 14'd1;
          rd_cnt <= rd_cnt + 1;
        end
        stg[0] <= rd_en ? fmem[fr] : {DSIZE{1'b1}};
        for (int k = 1; k < LAT; k++) stg[k] <= stg[k-1];
        if (tvalid && m_tready) begin
          pop_cnt <= pop_cnt + 1;
          bc_exp  <= bc_exp + 32'd1;
        end
      end
    end

    always @(negedge clk) begin
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL lane%0d beat with empty scoreboard: got 0x%0h, expected no beat", gi, tdata);
          end else begin
            check(gi, "beat data", 64'(tdata), 64'(exp_q.pop_front()));
          end
        end
        if (rd_en) check(gi, "rd_en while empty", 64'(empty), 64'd0);
        if (stall_prev) begin
          check(gi, "hold tvalid", 64'(tvalid), 64'd1);
          check(gi, "hold tdata", 64'(tdata), 64'(data_prev));
        end
        check(gi, "beat_cnt", 64'(bcnt), BEATCNT_EN ? 64'(bc_exp + bc_off) : 64'd0);
        stall_prev = tvalid && !m_tready;
        data_prev  = tdata;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_words(input int n, input logic [DSIZE-1:0] base);
    for (int k = 0; k < n; k++) begin
      wr_req  = 1'b1;
      wr_data = base + DSIZE'(k);
      g_lane[0].exp_q.push_back(wr_data);
      g_lane[1].exp_q.push_back(wr_data);
      tick();
    end
    wr_req = 1'b0;
  endtask

  task automatic sample_valid(input int n, output logic [31:0] h0, output logic [31:0] h1);
    h0 = '0;
    h1 = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      h0[k] = g_lane[0].tvalid;
      h1[k] = g_lane[1].tvalid;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] h0, h1;
    int          r0, r1, n;

    // Reset state
    repeat (3) tick();
    check(0, "reset tvalid", 64'(g_lane[0].tvalid), 64'd0);
    check(1, "reset tvalid", 64'(g_lane[1].tvalid), 64'd0);
    check(0, "reset rd_en",  64'(g_lane[0].rd_en),  64'd0);
    check(1, "reset rd_en",  64'(g_lane[1].rd_en),  64'd0);
    check(0, "reset tdata",  64'(g_lane[0].tdata),  64'd0);
    check(1, "reset tdata",  64'(g_lane[1].tdata),  64'd0);
    check(0, "reset beat_cnt", 64'(g_lane[0].bcnt), 64'd0);
    check(1, "reset beat_cnt", 64'(g_lane[1].bcnt), 64'd0);
    rst = 1'b0;
    repeat (2) tick();

    // 8-word burst, ready high: first valid LAT+1 cycles after empty falls, no bubbles
    m_tready = 1'b1;
    r0 = g_lane[0].rd_cnt;
    r1 = g_lane[1].rd_cnt;
    fork
      write_words(8, 18'd0);
      begin
        @(posedge clk);
        sample_valid(16, h0, h1);
      end
    join
    tick();
    check(0, "burst valid pattern", 64'(h0), 64'h0000_03FC);
    check(1, "burst valid pattern", 64'(h1), 64'h0000_07F8);
    check(0, "burst rd_en count", 64'(g_lane[0].rd_cnt - r0), 64'd8);
    check(1, "burst rd_en count", 64'(g_lane[1].rd_cnt - r1), 64'd8);

    // Backpressure: only BUF_DEPTH strobes while stalled, then 16 back-to-back beats
    m_tready = 1'b0;
    r0 = g_lane[0].rd_cnt;
    r1 = g_lane[1].rd_cnt;
    write_words(16, 18'd0);
    repeat (10) tick();
    check(0, "stall rd_en count", 64'(g_lane[0].rd_cnt - r0), 64'd2);
    check(1, "stall rd_en count", 64'(g_lane[1].rd_cnt - r1), 64'd3);
    check(0, "stall tvalid", 64'(g_lane[0].tvalid), 64'd1);
    check(1, "stall tvalid", 64'(g_lane[1].tvalid), 64'd1);
    check(0, "stall tdata", 64'(g_lane[0].tdata), 64'd0);
    check(1, "stall tdata", 64'(g_lane[1].tdata), 64'd0);
    m_tready = 1'b1;
    sample_valid(20, h0, h1);
    tick();
    check(0, "drain valid pattern", 64'(h0), 64'h0000_FFFF);
    check(1, "drain valid pattern", 64'(h1), 64'h0000_FFFF);

    // Single word: one strobe, one beat after LAT+1 cycles, nothing spurious afterwards
    r0 = g_lane[0].rd_cnt;
    r1 = g_lane[1].rd_cnt;
    fork
      write_words(1, 18'h155);
      begin
        @(posedge clk);
        sample_valid(10, h0, h1);
      end
    join
    tick();
    check(0, "single valid pattern", 64'(h0), 64'h0000_0004);
    check(1, "single valid pattern", 64'(h1), 64'h0000_0008);
    check(0, "single rd_en count", 64'(g_lane[0].rd_cnt - r0), 64'd1);
    check(1, "single rd_en count", 64'(g_lane[1].rd_cnt - r1), 64'd1);

    // Random writes and random ready, 10k words
    n = 0;
    while (n < 10000) begin
      wr_req = 1'($urandom_range(0, 1));
      if (wr_req) begin
        wr_data = DSIZE'($urandom);
        g_lane[0].exp_q.push_back(wr_data);
        g_lane[1].exp_q.push_back(wr_data);
        n++;
      end
      m_tready = 1'($urandom_range(0, 1));
      tick();
    end
    wr_req   = 1'b0;
    m_tready = 1'b1;
    for (int k = 0; k < 20000 && (g_lane[0].exp_q.size() != 0 || g_lane[1].exp_q.size() != 0); k++) tick();
    check(0, "random drain leftover", 64'(g_lane[0].exp_q.size()), 64'd0);
    check(1, "random drain leftover", 64'(g_lane[1].exp_q.size()), 64'd0);

    // Reset with beats buffered and in flight
    m_tready = 1'b0;
    write_words(3, 18'h3A0);
    rst = 1'b1;
    #1;
    check(0, "async reset tvalid", 64'(g_lane[0].tvalid), 64'd0);
    check(1, "async reset tvalid", 64'(g_lane[1].tvalid), 64'd0);
    check(0, "async reset rd_en",  64'(g_lane[0].rd_en),  64'd0);
    check(1, "async reset rd_en",  64'(g_lane[1].rd_en),  64'd0);
    g_lane[0].exp_q.delete();
    g_lane[1].exp_q.delete();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    m_tready = 1'b1;
    write_words(1, 18'h0A5);
    repeat (10) tick();
    check(0, "post-reset beat count", 64'(g_lane[0].pop_cnt), 64'd1);
    check(1, "post-reset beat count", 64'(g_lane[1].pop_cnt), 64'd1);
    check(0, "post-reset leftover", 64'(g_lane[0].exp_q.size()), 64'd0);
    check(1, "post-reset leftover", 64'(g_lane[1].exp_q.size()), 64'd0);

    // Beat counter
`ifdef FIFO_RD_ADAPTER_BEATCNT_EN
    m_tready = 1'b0;
    tick();
    force g_lane[0].u_dut.beat_cnt_q = 32'hFFFF_FFFE;
    force g_lane[1].u_dut.beat_cnt_q = 32'hFFFF_FFFE;
    g_lane[0].bc_off = 32'hFFFF_FFFE - g_lane[0].bc_exp;
    g_lane[1].bc_off = 32'hFFFF_FFFE - g_lane[1].bc_exp;
    tick();
    release g_lane[0].u_dut.beat_cnt_q;
    release g_lane[1].u_dut.beat_cnt_q;
    m_tready = 1'b1;
    write_words(3, 18'h0C0);
    repeat (10) tick();
    check(0, "beat_cnt after wrap", 64'(g_lane[0].bcnt), 64'd1);
    check(1, "beat_cnt after wrap", 64'(g_lane[1].bcnt), 64'd1);
`else
    m_tready = 1'b1;
    write_words(3, 18'h0C0);
    repeat (10) tick();
    check(0, "beat_cnt disabled", 64'(g_lane[0].bcnt), 64'd0);
    check(1, "beat_cnt disabled", 64'(g_lane[1].bcnt), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
